// File: rtl/core_pipe_pkg.sv
// Shared pipeline types and constants for the core's stage buffers.
// Holds the canonical NOP encoding, the occupancy encoding and the standard stage bundle widths.
// No logic; imported by the stage buffer, its entry register and its interface users.
package core_pipe_pkg;

    // addi x0, x0, 0 -- the architectural NOP used as the canonical bubble payload
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Standard flattened bundle widths for the classic stage boundaries
    localparam int IF_ID_DATA_W  = 96;  // pc, pc+4, instr
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_DATA_W  = 96;  // pc+4, imm, rd/rs fields
    localparam int ID_EX_CTRL_W  = 8;   // we_reg, we_mem, is_load, alu op ...
    localparam int EX_MEM_DATA_W = 96;  // alu result, store data, rd
    localparam int EX_MEM_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;  // writeback value, rd
    localparam int MEM_WB_CTRL_W = 2;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bundle between an upstream stage, the stage buffer and the downstream stage.
// No latency of its own; carries flush and occupancy alongside the two handshakes.
// master drives the upstream side and consumes the downstream side; slave is the buffer.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_entry.sv
// One payload register (data + control) that loads a new value or clears to the NOP bubble.
// Updates on the clock edge after load/clear; clear and reset win over load.
// No handshake of its own; the owning stage decides when to load or clear.
module pipe_stage_entry #(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 8,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    // Bubble on reset/clear, otherwise capture when told to
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q_data <= NOP_DATA;
            q_ctrl <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main (head) + skid entry, registered in_ready, synchronous flush to NOP.
// 1 cycle from accept to out_valid; sustains 1 entry/cycle while out_ready stays high.
// in_ready = !skid occupied, from a register; optional PIPE_STAGE_BUF_PERF_EN adds stall/flush counters.
module pipe_stage_buf
    import core_pipe_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 8,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PIPE_STAGE_BUF_PERF_EN
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
`endif
    pipe_stage_buf_if.slave       bus
);

    occ_e              occ;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] skid_q_data;
    logic [CTRL_W-1:0] skid_q_ctrl;

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    // Entry steering: main refills from skid when FULL, else from the input;
    // an entry leaving a register (or a flush) clears it back to the bubble
    always_comb begin
        main_load   = 1'b0;
        main_clear  = bus.flush;
        skid_load   = 1'b0;
        skid_clear  = bus.flush;
        main_d_data = bus.in_data;
        main_d_ctrl = bus.in_ctrl;
        case (occ)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
                main_load  = accept && drain;
                skid_load  = accept && !drain;
                main_clear = bus.flush || (drain && !accept);
            end
            OCC_FULL: begin
                main_d_data = skid_q_data;
                main_d_ctrl = skid_q_ctrl;
                main_load   = drain;
                skid_clear  = bus.flush || drain;
            end
            default: ;
        endcase
    end

    // Occupancy FSM with registered out_valid / in_ready; reset beats flush beats handshakes
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            occ         <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (occ)
                OCC_EMPTY: if (accept) begin
                    occ         <= OCC_ONE;
                    out_valid_q <= 1'b1;
                end
                OCC_ONE: begin
                    if (accept && !drain) begin
                        occ        <= OCC_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!accept && drain) begin
                        occ         <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                OCC_FULL: if (drain) begin
                    occ        <= OCC_ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    occ         <= OCC_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP_DATA)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .q_data (bus.out_data),
        .q_ctrl (bus.out_ctrl)
    );

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP_DATA)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_data (bus.in_data),
        .d_ctrl (bus.in_ctrl),
        .q_data (skid_q_data),
        .q_ctrl (skid_q_ctrl)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.occupancy = occ;

`ifdef PIPE_STAGE_BUF_PERF_EN
    // Saturating stall and flush-with-content counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (bus.flush && occ != OCC_EMPTY && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    // Upstream must hold its payload while stalled (a flush releases it)
    a_in_stable: assert property (@(posedge clk) disable iff (rst || bus.flush)
        (bus.in_valid && !in_ready_q) |=> (!bus.in_valid || ($stable(bus.in_data) && $stable(bus.in_ctrl))));

    // Only two entries exist
    a_occ_range: assert property (@(posedge clk) disable iff (rst) occ != 2'd3);

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
    import core_pipe_pkg::*;

    localparam int          DW  = 96;
    localparam int          CW  = 8;
    localparam logic [95:0] NOP = 96'h13;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef PIPE_STAGE_BUF_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [95:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 96'd5;
        bus.in_ctrl   = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
        chk("rst_out_data",  bus.out_data, NOP);
        chk("rst_out_ctrl",  96'(bus.out_ctrl), 96'd0);
        chk("rst_occ",       96'(bus.occupancy), 96'd0);
        chk("rst_in_ready",  96'(bus.in_ready), 96'd1);

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("idle_out_valid", 96'(bus.out_valid), 96'd0);

        // Streaming 1..4 with out_ready held high
        bus.out_ready = 1'b1;
        bus.in_ctrl   = 8'hA5;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 96'(i);
            step();
            chk("stream_valid", 96'(bus.out_valid), 96'd1);
            chk("stream_data",  bus.out_data, 96'(i));
            chk("stream_ctrl",  96'(bus.out_ctrl), 96'hA5);
            chk("stream_occ",   96'(bus.occupancy), 96'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_end_valid", 96'(bus.out_valid), 96'd0);
        chk("stream_end_data",  bus.out_data, NOP);
        chk("stream_end_ctrl",  96'(bus.out_ctrl), 96'd0);

        // Backpressure: 10, 11 fill both entries, 12 must wait
        bus.out_ready = 1'b0;
        bus.in_ctrl   = 8'h3C;
        push(96'd10);
        chk("bp_occ1", 96'(bus.occupancy), 96'd1);
        push(96'd11);
        chk("bp_occ2",     96'(bus.occupancy), 96'd2);
        chk("bp_in_ready", 96'(bus.in_ready), 96'd0);
        chk("bp_head10",   bus.out_data, 96'd10);
        bus.in_valid = 1'b1;
        bus.in_data  = 96'd12;
        step();
        chk("bp_no_accept_occ", 96'(bus.occupancy), 96'd2);
        chk("bp_no_accept_head", bus.out_data, 96'd10);
        bus.out_ready = 1'b1;
        step();
        chk("bp_head11", bus.out_data, 96'd11);
        chk("bp_occ_after11", 96'(bus.occupancy), 96'd1);
        step();
        chk("bp_head12", bus.out_data, 96'd12);
        chk("bp_ctrl12", 96'(bus.out_ctrl), 96'h3C);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained_valid", 96'(bus.out_valid), 96'd0);
        chk("bp_drained_occ",   96'(bus.occupancy), 96'd0);

        // Flush colliding with an input while FULL
        bus.out_ready = 1'b0;
        push(96'd10);
        push(96'd11);
        chk("fl_pre_occ", 96'(bus.occupancy), 96'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 96'd99;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ",       96'(bus.occupancy), 96'd0);
        chk("fl_out_valid", 96'(bus.out_valid), 96'd0);
        chk("fl_out_ctrl",  96'(bus.out_ctrl), 96'd0);
        chk("fl_out_data",  bus.out_data, NOP);
        chk("fl_in_ready",  96'(bus.in_ready), 96'd1);
        bus.out_ready = 1'b1;
        step();
        chk("fl_no99_valid", 96'(bus.out_valid), 96'd0);
        chk("fl_no99_data",  bus.out_data, NOP);

        // Reset while FULL with out_ready high
        bus.out_ready = 1'b0;
        push(96'd20);
        push(96'd21);
        chk("rf_pre_occ", 96'(bus.occupancy), 96'd2);
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        chk("rf_occ",       96'(bus.occupancy), 96'd0);
        chk("rf_out_valid", 96'(bus.out_valid), 96'd0);
        chk("rf_out_data",  bus.out_data, NOP);
        chk("rf_in_ready",  96'(bus.in_ready), 96'd1);
        step();
        chk("rf_no_deliver", 96'(bus.out_valid), 96'd0);

        // Hold: stalled single entry stays put; counts 5 stall cycles when enabled
        bus.out_ready = 1'b0;
        push(96'd30);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", bus.out_data, 96'd30);
        end
        chk("hold_occ", 96'(bus.occupancy), 96'd1);
`ifdef PIPE_STAGE_BUF_PERF_EN
        chk("perf_stall5", 96'(perf_stall_cnt), 96'd5);
        chk("perf_flush0", 96'(perf_flush_cnt), 96'd0);
`endif
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("perf_fl_occ", 96'(bus.occupancy), 96'd0);
`ifdef PIPE_STAGE_BUF_PERF_EN
        chk("perf_stall_final", 96'(perf_stall_cnt), 96'd5);
        chk("perf_flush_final", 96'(perf_flush_cnt), 96'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed IF_ID/ID_EX/EX_MEM/MEM_WB stage registers.
- Generic elastic pipeline stage with a valid/ready handshake and a 2-entry skid buffer, so a stage can be back-pressured without a combinational ready path.
- Has a synchronous flush and a canonical bubble: on flush or when empty, the payload is NOP_DATA and the control bits are zero.
- Instantiated between any two core stages; the payload is a flattened bundle of PC, immediates, rd and so on.

Parameters:
- DATA_W, 96, width of the datapath payload (PC, PC+4, instruction/immediates, ...).
- CTRL_W, 8, width of the control payload (we_reg, we_mem, is_load, ...); forced to 0 on every bubble.
- NOP_DATA, {DATA_W{1'b0}} with bits [31:0]=32'h00000013, payload presented whenever no valid entry exists.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  kill all held entries (branch/jump redirect).
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head datapath payload.
- out_ctrl  out  CTRL_W  head control payload.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage and ordering:
  - Two entries: main (head) and skid. Outputs always reflect main.
  - FIFO order is preserved.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Drain occurs when out_valid && out_ready.
  - in_ready = !skid_valid, registered. It never depends combinationally on out_ready.
- States (occupancy):
  - EMPTY(0): accept -> ONE.
  - ONE(1):
    - accept && drain -> ONE (main takes in_data).
    - accept && !drain -> FULL (in_data goes to skid).
    - !accept && drain -> EMPTY.
    - neither -> hold.
  - FULL(2): accept is impossible because in_ready=0.
    - drain -> ONE (skid moves to main, skid cleared).
    - otherwise hold.
- Latency and throughput:
  - 1 cycle from accept to out_valid when EMPTY.
  - Sustained 1 entry/cycle with out_ready held high.
- Bubble rule:
  - When out_valid=0: out_data=NOP_DATA and out_ctrl=0, regardless of history.
  - When an entry leaves the skid register, that register is written with NOP_DATA/0.
- Flush:
  - Synchronous. The next state is EMPTY with both entries cleared to NOP_DATA/0.
  - Flush has priority over a simultaneous accept (input dropped) and a simultaneous drain (out_valid still 1 in the flush cycle, so downstream may consume the old head).
  - in_ready=1 on the cycle after a flush.
- Reset:
  - Identical to flush: occupancy=0, out_valid=0, in_ready=1, out_data=NOP_DATA, out_ctrl=0.
  - Reset overrides flush and handshakes, including mid-transfer from FULL.
- Hold: with out_ready=0 and in_valid=0, all registers are stable indefinitely.
- Assertions (sim only):
  - in_data/in_ctrl must not change while in_valid && !in_ready; violations are flagged.
  - occupancy never reaches 3.

Optional Feature:
- PIPE_STAGE_BUF_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle with out_valid && !out_ready.
  - perf_flush_cnt increments each cycle with flush=1 and occupancy>0.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: these ports and counters are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package core_pipe_pkg:
  - constant NOP_INSTR=32'h00000013.
  - occupancy enum {OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2}.
  - localparams for the standard stage bundle widths (IF_ID_DATA_W, ID_EX_DATA_W, ID_EX_CTRL_W, ...).
- One natural sub-module, pipe_stage_entry: a single DATA_W+CTRL_W register with load/clear-to-NOP controls, instantiated twice (main, skid).

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1, in_data=5.
  - Required: out_valid=0, out_data[31:0]=32'h13, out_ctrl=0, occupancy=0, in_ready=1.
- Streaming:
  - Stimulus: out_ready=1; push in_data=1,2,3,4 on consecutive cycles, ctrl=8'hA5.
  - Required: outputs 1,2,3,4 on cycles +1..+4, each with out_ctrl=8'hA5; occupancy stays at 1.
- Backpressure:
  - Stimulus: out_ready=0; push 10, then 11.
  - Required: occupancy=2 and in_ready=0 on the next cycle; a third push of 12 is not accepted.
  - Stimulus: raise out_ready.
  - Required: 10, 11, 12 emerge in order, with no loss or duplication.
- Flush collision:
  - Stimulus: occupancy=2 (10, 11); flush=1 together with in_valid=1, in_data=99.
  - Required: next cycle occupancy=0, out_valid=0, out_ctrl=0, and 99 never appears.
- Reset mid-FULL:
  - Stimulus: occupancy=2, out_ready=1, rst=1.
  - Required: next cycle EMPTY/NOP state, and no entry is delivered after reset.
- Perf (with PIPE_STAGE_BUF_PERF_EN):
  - Stimulus: 5 stalled cycles, then 1 flush with occupancy=1.
  - Required: perf_stall_cnt=5, perf_flush_cnt=1.
